// File: rtl/sweep_pkg.sv
// Shared constants for the truth-table sweeper: FSM state encoding and default sizing.
package sweep_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int DEF_N_IN       = 4;
    localparam int DEF_SETTLE_CYC = 1;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-time down-counter: load starts a SETTLE_CYC-cycle window, expire_o marks its last cycle.
import sweep_pkg::*;

module sweep_settle_timer #(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload on entry to SETTLE, count down while settling.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != {CW{1'b0}})) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked truth-table sweep of a combinational block with compare against an expected mask.
// Optional error statistics (err_cnt, first_err) enabled by defining SWEEP_ERR_CNT_EN.
import sweep_pkg::*;

module truth_table_sweeper #(
    parameter int N_IN       = DEF_N_IN,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp_mask,
    output logic [N_IN-1:0]      vec,
    input  logic                 s_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 pass,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      first_err
);

    localparam int TW = 2**N_IN;
    localparam logic [N_IN:0] IDX_LAST = (N_IN+1)'(TW - 1);

    logic [1:0]      state_q, state_d;
    logic [N_IN:0]   idx_q, idx_d;
    logic [TW-1:0]   mask_q, mask_d;
    logic [TW-1:0]   table_q, table_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_cnt_q, err_cnt_d;
    logic [N_IN-1:0] first_err_q, first_err_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tmr_load_s;
    logic            tmr_en_s;
    logic            tmr_expire_s;

    sweep_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tmr_load_s),
        .en_i     (tmr_en_s),
        .expire_o (tmr_expire_s)
    );

    // Sweep FSM, index walk, table capture and compare.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        table_d     = table_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        tmr_load_s  = 1'b0;
        tmr_en_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SETTLE;
                    mask_d      = exp_mask;
                    idx_d       = {(N_IN+1){1'b0}};
                    table_d     = {TW{1'b0}};
                    pass_d      = 1'b0;
                    err_cnt_d   = {(N_IN+1){1'b0}};
                    first_err_d = {N_IN{1'b0}};
                    tmr_load_s  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                tmr_en_s = 1'b1;
                if (tmr_expire_s) begin
                    state_d = S_SAMPLE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SAMPLE: begin
                table_d[idx_q[N_IN-1:0]] = s_in;
`ifdef SWEEP_ERR_CNT_EN
                if (s_in != mask_q[idx_q[N_IN-1:0]]) begin
                    err_cnt_d = err_cnt_q + (N_IN+1)'(1);
                    if (err_cnt_q == {(N_IN+1){1'b0}}) begin
                        first_err_d = idx_q[N_IN-1:0];
                    end else begin
                        first_err_d = first_err_q;
                    end
                end else begin
                    err_cnt_d = err_cnt_q;
                end
`endif
                // pass must see the final write, so compare the next-state table.
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                    pass_d  = (table_d == mask_q);
                end else begin
                    state_d    = S_SETTLE;
                    idx_d      = idx_q + (N_IN+1)'(1);
                    tmr_load_s = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output registers are derived from the next state so they align with it.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        if ((state_d == S_SETTLE) || (state_d == S_SAMPLE)) begin
            vec_d = idx_d[N_IN-1:0];
        end else begin
            vec_d = {N_IN{1'b0}};
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= {(N_IN+1){1'b0}};
            mask_q      <= {TW{1'b0}};
            table_q     <= {TW{1'b0}};
            pass_q      <= 1'b0;
            err_cnt_q   <= {(N_IN+1){1'b0}};
            first_err_q <= {N_IN{1'b0}};
            vec_q       <= {N_IN{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            table_q     <= table_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            vec_q       <= vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign vec       = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: random functions against a truth-table reference model.
module tb_truth_table_sweeper;

`ifdef SWEEP_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start1 = 1'b0;
    logic [15:0] exp1 = 16'h0;
    logic [3:0]  vec1;
    logic        s1;
    logic        busy1, done1, pass1;
    logic [15:0] tab1;
    logic [4:0]  err1;
    logic [3:0]  ferr1;
    logic [15:0] tt1 = 16'h0;
    logic        force1 = 1'b0;

    logic        start3 = 1'b0;
    logic [15:0] exp3 = 16'h0;
    logic [3:0]  vec3;
    logic        s3;
    logic        busy3, done3, pass3;
    logic [15:0] tab3;
    logic [4:0]  err3;
    logic [3:0]  ferr3;
    logic [15:0] tt3 = 16'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // The "function block": a truth table lookup driven by vec.
    assign s1 = force1 ? 1'b1 : tt1[vec1];
    assign s3 = tt3[vec3];

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .exp_mask(exp1), .vec(vec1), .s_in(s1),
        .busy(busy1), .done(done1), .table_out(tab1), .pass(pass1), .err_cnt(err1), .first_err(ferr1)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .exp_mask(exp3), .vec(vec3), .s_in(s3),
        .busy(busy3), .done(done3), .table_out(tab3), .pass(pass3), .err_cnt(err3), .first_err(ferr3)
    );

    function automatic logic [4:0] ref_errs(input logic [15:0] got, input logic [15:0] exp);
        logic [15:0] diff;
        diff = got ^ exp;
        return ERR_EN ? 5'($countones(diff)) : 5'd0;
    endfunction

    function automatic logic [3:0] ref_first(input logic [15:0] got, input logic [15:0] exp);
        logic [15:0] diff;
        logic [3:0]  r;
        diff = got ^ exp;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) r = 4'(i);
        end
        return ERR_EN ? r : 4'd0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start1 = 1'b1;
        exp1 = 16'hA5A5;
        repeat (3) @(negedge clk);
        checks++;
        if (vec1 !== 4'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || tab1 !== 16'h0 ||
            pass1 !== 1'b0 || err1 !== 5'd0 || ferr1 !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: vec=%0h busy=%0b done=%0b table=%h pass=%0b err=%0d first=%0d, required all zero",
                     vec1, busy1, done1, tab1, pass1, err1, ferr1);
        end
        start1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One full sweep on dut; extra start pulses while busy are optionally injected.
    task automatic sweep1(input string name, input logic [15:0] tt, input logic [15:0] exp,
                          input bit tie1, input bit extra);
        logic [15:0] eff;
        logic [3:0]  ev;
        int          done_n;
        int          done_seen;
        logic        pass_at_done;
        eff = tie1 ? 16'hFFFF : tt;
        tt1 = tt;
        force1 = tie1;
        start1 = 1'b1;
        exp1 = exp;
        done_n = 0;
        done_seen = 0;
        pass_at_done = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n <= 33) begin
                checks++;
                if (busy1 !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_busy: cycle %0d busy=%0b required 1", name, n, busy1);
                end
            end
            if (n <= 32) begin
                ev = 4'((n - 1) / 2);
                checks++;
                if (vec1 !== ev) begin
                    errors++;
                    $display("FAIL %s_vec: cycle %0d vec=%0d required %0d", name, n, vec1, ev);
                end
            end
            if (done1 === 1'b1) begin
                done_seen++;
                done_n = n;
                pass_at_done = pass1;
            end
            start1 = (extra && (n == 4 || n == 17 || n == 33)) ? 1'b1 : 1'b0;
            exp1 = 16'($urandom);
        end
        checks++;
        if (done_seen != 1 || done_n != 33) begin
            errors++;
            $display("FAIL %s_done: pulses=%0d at cycle %0d, required 1 at cycle 33", name, done_seen, done_n);
        end
        checks++;
        if (pass_at_done !== (eff == exp)) begin
            errors++;
            $display("FAIL %s_pass_at_done: pass=%0b required %0b", name, pass_at_done, (eff == exp));
        end
        checks++;
        if (tab1 !== eff || pass1 !== (eff == exp) || busy1 !== 1'b0 || vec1 !== 4'd0) begin
            errors++;
            $display("FAIL %s_result: table=%h pass=%0b busy=%0b vec=%0d, required table=%h pass=%0b busy=0 vec=0",
                     name, tab1, pass1, busy1, vec1, eff, (eff == exp));
        end
        checks++;
        if (err1 !== ref_errs(eff, exp) || ferr1 !== ref_first(eff, exp)) begin
            errors++;
            $display("FAIL %s_errstat: err_cnt=%0d first_err=%0d, required %0d %0d",
                     name, err1, ferr1, ref_errs(eff, exp), ref_first(eff, exp));
        end
        force1 = 1'b0;
    endtask

    task automatic test_known();
        sweep1("match", 16'h212F, 16'h212F, 1'b0, 1'b0);
        sweep1("mismatch", 16'h212F, 16'h212E, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] tt;
        logic [15:0] flips;
        for (int i = 0; i < 4; i++) begin
            tt = 16'($urandom);
            flips = (i == 0) ? 16'h0 : (16'($urandom) & 16'($urandom) & 16'($urandom));
            sweep1("random", tt, tt ^ flips, 1'b0, 1'b0);
        end
    endtask

    task automatic test_start_while_busy();
        sweep1("busy_start", 16'($urandom), 16'hFFFF, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit reached;
        tt1 = 16'($urandom) | 16'h00FF;
        start1 = 1'b1;
        exp1 = tt1;
        @(negedge clk);
        start1 = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 40 && !reached; n++) begin
            if (vec1 === 4'd7) reached = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL midreset_reach: vec=%0d never reached 7", vec1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || vec1 !== 4'd0 || tab1 !== 16'h0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: busy=%0b vec=%0d table=%h done=%0b, required 0 0 0000 0",
                     busy1, vec1, tab1, done1);
        end
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if (done1 !== 1'b0 || busy1 !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet: done=%0b busy=%0b required 0 0", done1, busy1);
            end
        end
        sweep1("after_reset", 16'($urandom), 16'h212F, 1'b0, 1'b0);
    endtask

    task automatic test_settle3();
        logic [15:0] tt;
        logic [3:0]  ev;
        int          done_n;
        int          done_seen;
        tt = 16'h212F;
        tt3 = tt;
        start3 = 1'b1;
        exp3 = tt;
        done_n = 0;
        done_seen = 0;
        for (int n = 1; n <= 72; n++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (n <= 64) begin
                ev = 4'((n - 1) / 4);
                checks++;
                if (vec3 !== ev || busy3 !== 1'b1) begin
                    errors++;
                    $display("FAIL settle3_vec: cycle %0d vec=%0d busy=%0b required %0d 1", n, vec3, busy3, ev);
                end
            end
            if (done3 === 1'b1) begin
                done_seen++;
                done_n = n;
            end
        end
        checks++;
        if (done_seen != 1 || done_n != 65) begin
            errors++;
            $display("FAIL settle3_done: pulses=%0d at cycle %0d, required 1 at cycle 65", done_seen, done_n);
        end
        checks++;
        if (tab3 !== tt || pass3 !== 1'b1 || err3 !== 5'd0) begin
            errors++;
            $display("FAIL settle3_result: table=%h pass=%0b err=%0d, required %h 1 0", tab3, pass3, err3, tt);
        end
    endtask

    task automatic test_back_to_back();
        int times[3];
        int cnt;
        int extra;
        tt1 = 16'($urandom);
        start1 = 1'b1;
        exp1 = tt1;
        cnt = 0;
        for (int n = 1; n <= 140 && cnt < 3; n++) begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                times[cnt] = n;
                checks++;
                if (pass1 !== 1'b1 || tab1 !== tt1) begin
                    errors++;
                    $display("FAIL b2b_pass: sweep %0d pass=%0b table=%h required 1 %h", cnt, pass1, tab1, tt1);
                end
                cnt++;
                if (cnt == 3) start1 = 1'b0;
            end
        end
        start1 = 1'b0;
        checks++;
        if (cnt != 3) begin
            errors++;
            $display("FAIL b2b_count: done pulses=%0d required 3", cnt);
        end else begin
            checks++;
            if (times[1] - times[0] != 34 || times[2] - times[1] != 34) begin
                errors++;
                $display("FAIL b2b_spacing: gaps %0d %0d required 34 34", times[1] - times[0], times[2] - times[1]);
            end
        end
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done1 === 1'b1 || busy1 === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL b2b_stop: %0d busy/done cycles after start dropped, required 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_random();
        test_start_while_busy();
        test_reset_mid();
        test_settle3();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
